// File: rtl/display_scan_ctrl_if.sv
// Bundle of display-side signals between a value producer and the scan controller.
// The producer drives the load strobe and value; the controller drives the scan outputs.
interface display_scan_ctrl_if;
  logic        load;
  logic [31:0] data_in;
  logic [7:0]  dot_in;
  logic [7:0]  en_in;
  logic [2:0]  digit_sel;
  logic [7:0]  seg;
  logic        pending;
  logic        frame_done;

  modport master (
    output load, data_in, dot_in, en_in,
    input  digit_sel, seg, pending, frame_done
  );

  modport slave (
    input  load, data_in, dot_in, en_in,
    output digit_sel, seg, pending, frame_done
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 8-digit seven-segment scan controller with a double-buffered
// hex value that is swapped in only at frame boundaries (no torn frames).
module display_scan_ctrl #(
  parameter int unsigned SCAN_DIV     = 4,  // clocks per digit slot, >= 2
  parameter int unsigned BLANK_CYCLES = 1   // leading blank clocks per slot, < SCAN_DIV
) (
  input  logic               clk,
  input  logic               rst,
  display_scan_ctrl_if.slave bus
);

  localparam int unsigned    CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYCLES);

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'b1000000;
      4'h1:    pat = 7'b1111001;
      4'h2:    pat = 7'b0100100;
      4'h3:    pat = 7'b0110000;
      4'h4:    pat = 7'b0011001;
      4'h5:    pat = 7'b0010010;
      4'h6:    pat = 7'b0000010;
      4'h7:    pat = 7'b1111000;
      4'h8:    pat = 7'b0000000;
      4'h9:    pat = 7'b0010000;
      4'hA:    pat = 7'b0001000;
      4'hB:    pat = 7'b0000011;
      4'hC:    pat = 7'b1000110;
      4'hD:    pat = 7'b0100001;
      4'hE:    pat = 7'b0000110;
      4'hF:    pat = 7'b0001110;
      default: pat = 7'b1111111;
    endcase
    return pat;
  endfunction

  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [2:0]       digit_q,     digit_d;
  logic [31:0]      act_data_q,  act_data_d;
  logic [7:0]       act_dot_q,   act_dot_d;
  logic [7:0]       act_en_q,    act_en_d;
  logic [31:0]      sh_data_q,   sh_data_d;
  logic [7:0]       sh_dot_q,    sh_dot_d;
  logic [7:0]       sh_en_q,     sh_en_d;
  logic             pending_q,   pending_d;
  logic             frame_q,     frame_d;

  logic             tick_s;
  logic             boundary_s;
  logic [4:0]       nib_base_s;
  logic [3:0]       nib_s;
  logic [7:0]       seg_s;

  assign tick_s     = (cnt_q == CNT_LAST);
  assign boundary_s = tick_s && (digit_q == 3'd7);

  // Next-state: prescaler, digit index, shadow/active buffers and pending flag.
  always_comb begin
    cnt_d      = cnt_q;
    digit_d    = digit_q;
    act_data_d = act_data_q;
    act_dot_d  = act_dot_q;
    act_en_d   = act_en_q;
    sh_data_d  = sh_data_q;
    sh_dot_d   = sh_dot_q;
    sh_en_d    = sh_en_q;
    pending_d  = pending_q;
    frame_d    = boundary_s;

    if (tick_s) begin
      cnt_d   = '0;
      digit_d = digit_q + 3'd1;
    end else begin
      cnt_d   = cnt_q + CNT_W'(1);
    end

    if (bus.load) begin
      sh_data_d = bus.data_in;
      sh_dot_d  = bus.dot_in;
      sh_en_d   = bus.en_in;
    end else begin
      sh_data_d = sh_data_q;
    end

    // A load landing on the boundary bypasses the shadow so it is not lost a frame.
    if (boundary_s && bus.load) begin
      act_data_d = bus.data_in;
      act_dot_d  = bus.dot_in;
      act_en_d   = bus.en_in;
      pending_d  = 1'b0;
    end else if (boundary_s && pending_q) begin
      act_data_d = sh_data_q;
      act_dot_d  = sh_dot_q;
      act_en_d   = sh_en_q;
      pending_d  = 1'b0;
    end else if (bus.load) begin
      pending_d  = 1'b1;
    end else begin
      pending_d  = pending_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      digit_q    <= 3'd0;
      act_data_q <= 32'h0000_0000;
      act_dot_q  <= 8'h00;
      act_en_q   <= 8'h00;
      sh_data_q  <= 32'h0000_0000;
      sh_dot_q   <= 8'h00;
      sh_en_q    <= 8'h00;
      pending_q  <= 1'b0;
      frame_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      digit_q    <= digit_d;
      act_data_q <= act_data_d;
      act_dot_q  <= act_dot_d;
      act_en_q   <= act_en_d;
      sh_data_q  <= sh_data_d;
      sh_dot_q   <= sh_dot_d;
      sh_en_q    <= sh_en_d;
      pending_q  <= pending_d;
      frame_q    <= frame_d;
    end
  end

  assign nib_base_s = {digit_q, 2'b00};
  assign nib_s      = act_data_q[nib_base_s +: 4];

  // Segment drive: decoded only from registered state, so it changes solely on clock edges.
  always_comb begin
    seg_s = 8'hFF;
    if ((cnt_q < BLANK_LIM) || !act_en_q[digit_q]) begin
      seg_s = 8'hFF;
    end else begin
      seg_s = {~act_dot_q[digit_q], hex_to_seg(nib_s)};
    end
  end

  assign bus.digit_sel  = digit_q;
  assign bus.seg        = seg_s;
  assign bus.pending    = pending_q;
  assign bus.frame_done = frame_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl; slot position is tracked by counting
// clock edges since the last reset.
module tb_display_scan_ctrl;
  localparam int SCAN_DIV = 4;
  localparam int FRAME    = 8 * SCAN_DIV;

  logic clk;
  logic rst;
  int   ph;
  int   n_checks;
  int   n_pass;

  display_scan_ctrl_if dif ();

  display_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .BLANK_CYCLES(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    if (rst) ph = 0;
    else     ph = ph + 1;
    @(negedge clk);
  endtask

  task automatic goto(input int d, input int c);
    int tgt;
    int n;
    tgt = d * SCAN_DIV + c;
    n   = 0;
    while (((ph % FRAME) != tgt) && (n < 2 * FRAME)) begin
      cycle();
      n++;
    end
  endtask

  task automatic do_load(input logic [31:0] d, input logic [7:0] dot, input logic [7:0] en);
    dif.load    = 1'b1;
    dif.data_in = d;
    dif.dot_in  = dot;
    dif.en_in   = en;
    cycle();
    dif.load    = 1'b0;
  endtask

  task automatic test_reset();
    logic [2:0] exp_dig;
    logic       exp_fd;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_checks++;
      if (dif.digit_sel !== 3'd0 || dif.seg !== 8'hFF || dif.pending !== 1'b0 || dif.frame_done !== 1'b0)
        $display("FAIL reset_hold: dig=%0d seg=%h pend=%b fd=%b expected 0/ff/0/0",
                 dif.digit_sel, dif.seg, dif.pending, dif.frame_done);
      else n_pass++;
    end
    rst = 1'b0;
    for (int k = 1; k <= 33; k++) begin
      cycle();
      exp_dig = 3'((k / 4) % 8);
      exp_fd  = (k == 32);
      n_checks++;
      if (dif.digit_sel !== exp_dig || dif.frame_done !== exp_fd)
        $display("FAIL reset_scan cyc%0d: dig=%0d fd=%b expected %0d/%b",
                 k, dif.digit_sel, dif.frame_done, exp_dig, exp_fd);
      else n_pass++;
    end
  endtask

  task automatic test_basic();
    do_load(32'h7654_3210, 8'h01, 8'hFF);
    n_checks++;
    if (dif.pending !== 1'b1) $display("FAIL basic_pend: got %b expected 1", dif.pending);
    else n_pass++;
    goto(3, 2);
    n_checks++;
    if (dif.seg !== 8'hFF) $display("FAIL basic_dark: got %h expected ff", dif.seg);
    else n_pass++;
    goto(7, 3);
    n_checks++;
    if (dif.pending !== 1'b1) $display("FAIL basic_pend_hold: got %b expected 1", dif.pending);
    else n_pass++;
    cycle();
    n_checks++;
    if (dif.pending !== 1'b0 || dif.frame_done !== 1'b1)
      $display("FAIL basic_swap: pend=%b fd=%b expected 0/1", dif.pending, dif.frame_done);
    else n_pass++;
    n_checks++;
    if (dif.seg !== 8'hFF) $display("FAIL basic_s0_blank: got %h expected ff", dif.seg);
    else n_pass++;
    cycle();
    n_checks++;
    if (dif.seg !== 8'h40) $display("FAIL basic_s0: got %h expected 40", dif.seg);
    else n_pass++;
    goto(1, 2);
    n_checks++;
    if (dif.seg !== 8'hF9) $display("FAIL basic_s1: got %h expected f9", dif.seg);
    else n_pass++;
    goto(3, 1);
    n_checks++;
    if (dif.seg !== 8'hB0) $display("FAIL basic_s3: got %h expected b0", dif.seg);
    else n_pass++;
    goto(7, 3);
    n_checks++;
    if (dif.seg !== 8'hF8) $display("FAIL basic_s7: got %h expected f8", dif.seg);
    else n_pass++;
  endtask

  task automatic test_tearing();
    goto(2, 1);
    do_load(32'h1111_1111, 8'h00, 8'hFF);
    goto(4, 2);
    n_checks++;
    if (dif.seg !== 8'h99 || dif.pending !== 1'b1)
      $display("FAIL tear_old4: seg=%h pend=%b expected 99/1", dif.seg, dif.pending);
    else n_pass++;
    goto(5, 1);
    do_load(32'h2222_2222, 8'h00, 8'hFF);
    goto(6, 2);
    n_checks++;
    if (dif.seg !== 8'h82) $display("FAIL tear_old6: got %h expected 82", dif.seg);
    else n_pass++;
    goto(7, 3);
    n_checks++;
    if (dif.pending !== 1'b1 || dif.seg !== 8'hF8)
      $display("FAIL tear_old7: seg=%h pend=%b expected f8/1", dif.seg, dif.pending);
    else n_pass++;
    cycle();
    n_checks++;
    if (dif.pending !== 1'b0) $display("FAIL tear_pend_clr: got %b expected 0", dif.pending);
    else n_pass++;
    for (int d = 0; d < 8; d++) begin
      goto(d, 2);
      n_checks++;
      if (dif.seg !== 8'hA4) $display("FAIL tear_new s%0d: got %h expected a4", d, dif.seg);
      else n_pass++;
    end
  endtask

  task automatic test_collision();
    goto(7, 3);
    do_load(32'hFFFF_FFFF, 8'h00, 8'hFF);
    n_checks++;
    if (dif.pending !== 1'b0 || dif.frame_done !== 1'b1)
      $display("FAIL coll_pend: pend=%b fd=%b expected 0/1", dif.pending, dif.frame_done);
    else n_pass++;
    cycle();
    n_checks++;
    if (dif.seg !== 8'h8E) $display("FAIL coll_s0: got %h expected 8e", dif.seg);
    else n_pass++;
    goto(4, 2);
    n_checks++;
    if (dif.seg !== 8'h8E || dif.pending !== 1'b0)
      $display("FAIL coll_s4: seg=%h pend=%b expected 8e/0", dif.seg, dif.pending);
    else n_pass++;
  endtask

  task automatic test_enable();
    logic [7:0] exp;
    do_load(32'h7654_3210, 8'h00, 8'b1010_1010);
    goto(7, 3);
    cycle();
    for (int d = 0; d < 8; d++) begin
      for (int c = 0; c < SCAN_DIV; c++) begin
        goto(d, c);
        if ((d % 2) == 0 || c == 0) exp = 8'hFF;
        else begin
          case (d)
            1:       exp = 8'hF9;
            3:       exp = 8'hB0;
            5:       exp = 8'h92;
            default: exp = 8'hF8;
          endcase
        end
        n_checks++;
        if (dif.seg !== exp) $display("FAIL enable s%0d c%0d: got %h expected %h", d, c, dif.seg, exp);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid();
    goto(2, 0);
    do_load(32'h0000_0000, 8'hFF, 8'hFF);
    goto(4, 1);
    n_checks++;
    if (dif.pending !== 1'b1 || dif.digit_sel !== 3'd4)
      $display("FAIL rmid_pre: pend=%b dig=%0d expected 1/4", dif.pending, dif.digit_sel);
    else n_pass++;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    n_checks++;
    if (dif.digit_sel !== 3'd0 || dif.pending !== 1'b0 || dif.seg !== 8'hFF || dif.frame_done !== 1'b0)
      $display("FAIL rmid_post: dig=%0d pend=%b seg=%h fd=%b expected 0/0/ff/0",
               dif.digit_sel, dif.pending, dif.seg, dif.frame_done);
    else n_pass++;
    goto(7, 3);
    cycle();
    n_checks++;
    if (dif.frame_done !== 1'b1 || dif.pending !== 1'b0)
      $display("FAIL rmid_bound: fd=%b pend=%b expected 1/0", dif.frame_done, dif.pending);
    else n_pass++;
    cycle();
    n_checks++;
    if (dif.seg !== 8'hFF) $display("FAIL rmid_discard: got %h expected ff", dif.seg);
    else n_pass++;
  endtask

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    ph          = 0;
    rst         = 1'b1;
    dif.load    = 1'b0;
    dif.data_in = 32'h0000_0000;
    dif.dot_in  = 8'h00;
    dif.en_in   = 8'h00;
    test_reset();
    test_basic();
    test_tearing();
    test_collision();
    test_enable();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
